// File: rtl/pc_branch_ctrl_if.sv
// rtl/pc_branch_ctrl_if.sv - decode-side bus between the decoder and the PC/branch controller
interface pc_branch_ctrl_if;
    logic        i_stall;
    logic        i_branch;
    logic        i_branch_reg;
    logic [2:0]  i_ccc;
    logic [8:0]  i_imm9;
    logic [15:0] i_reg_target;
    logic        i_halt;
    logic [2:0]  i_flags;
    logic [2:0]  i_flags_next;
    logic        i_flags_wen;
    logic [15:0] o_pc;
    logic [15:0] o_pc_plus2;
    logic        o_taken;
    logic        o_flush;
    logic        o_halted;

    modport master (
        output i_stall, i_branch, i_branch_reg, i_ccc, i_imm9, i_reg_target,
               i_halt, i_flags, i_flags_next, i_flags_wen,
        input  o_pc, o_pc_plus2, o_taken, o_flush, o_halted
    );

    modport slave (
        input  i_stall, i_branch, i_branch_reg, i_ccc, i_imm9, i_reg_target,
               i_halt, i_flags, i_flags_next, i_flags_wen,
        output o_pc, o_pc_plus2, o_taken, o_flush, o_halted
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter with conditional B/BR redirect, one-cycle flush and halt
module pc_branch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    pc_branch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [2:0]  w_flags_eff;
    logic        w_z;
    logic        w_v;
    logic        w_n;
    logic        w_cond;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_br_target;
    logic        w_taken;

    // A flag write in the same cycle as the branch must be visible to it.
    assign w_flags_eff = bus.i_flags_wen ? bus.i_flags_next : bus.i_flags;
    assign w_z         = w_flags_eff[2];
    assign w_v         = w_flags_eff[1];
    assign w_n         = w_flags_eff[0];

    always_comb begin
        w_cond = 1'b1;
        case (bus.i_ccc)
            3'b000:  w_cond = ~w_z;
            3'b001:  w_cond = w_z;
            3'b010:  w_cond = ~w_z & ~w_n;
            3'b011:  w_cond = w_n;
            3'b100:  w_cond = w_z | ~w_n;
            3'b101:  w_cond = w_z | w_n;
            3'b110:  w_cond = w_v;
            default: w_cond = 1'b1;
        endcase
    end

    assign w_pc_plus2  = r_pc + 16'd2;
    assign w_br_target = w_pc_plus2 + {{6{bus.i_imm9[8]}}, bus.i_imm9, 1'b0};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_taken     = 1'b0;
        if (!bus.i_stall) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.i_halt) begin
                        w_state_nxt = ST_HALT;
                    end else if (bus.i_branch_reg) begin
                        // BR shadows a simultaneous B even when BR's condition fails.
                        if (w_cond) begin
                            w_pc_nxt    = bus.i_reg_target;
                            w_taken     = 1'b1;
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_pc_nxt = w_pc_plus2;
                        end
                    end else if (bus.i_branch && w_cond) begin
                        w_pc_nxt    = w_br_target;
                        w_taken     = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_pc_nxt = w_pc_plus2;
                    end
                end
                ST_FLUSH: begin
                    w_pc_nxt    = w_pc_plus2;
                    w_state_nxt = ST_RUN;
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign bus.o_pc       = r_pc;
    assign bus.o_pc_plus2 = w_pc_plus2;
    assign bus.o_taken    = w_taken;
    assign bus.o_flush    = (r_state == ST_FLUSH);
    assign bus.o_halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - scoreboard bench for pc_branch_ctrl with a behavioural reference model
module tb_pc_branch_ctrl;

    logic clk;
    logic rst;

    pc_branch_ctrl_if bif ();

    pc_branch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        branch;
        logic        branch_reg;
        logic [2:0]  ccc;
        logic [8:0]  imm9;
        logic [15:0] tgt;
        logic        halt;
        logic [2:0]  flags;
        logic [2:0]  flags_next;
        logic        flags_wen;
    } stim_t;

    typedef struct packed {
        logic        taken;
        logic [15:0] pc;
        logic        flush;
        logic        halted;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    int m_pc;
    bit m_halt;
    bit m_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit cond_true(input logic [2:0] ccc, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic [2:0] eff;
        bit c;
        int off;
        bif.i_stall      = s.stall;
        bif.i_branch     = s.branch;
        bif.i_branch_reg = s.branch_reg;
        bif.i_ccc        = s.ccc;
        bif.i_imm9       = s.imm9;
        bif.i_reg_target = s.tgt;
        bif.i_halt       = s.halt;
        bif.i_flags      = s.flags;
        bif.i_flags_next = s.flags_next;
        bif.i_flags_wen  = s.flags_wen;

        eff = s.flags_wen ? s.flags_next : s.flags;
        c   = cond_true(s.ccc, eff);
        off = s.imm9[8] ? int'(s.imm9) - 512 : int'(s.imm9);
        e.taken = 1'b0;
        if (s.stall || m_halt) begin
        end else if (m_flush) begin
            m_pc    = (m_pc + 2) % 65536;
            m_flush = 0;
        end else if (s.halt) begin
            m_halt = 1;
        end else if (s.branch_reg) begin
            if (c) begin
                m_pc = int'(s.tgt); e.taken = 1'b1; m_flush = 1;
            end else begin
                m_pc = (m_pc + 2) % 65536;
            end
        end else if (s.branch && c) begin
            m_pc = (m_pc + 2 + off * 2 + 65536 * 2) % 65536;
            e.taken = 1'b1; m_flush = 1;
        end else begin
            m_pc = (m_pc + 2) % 65536;
        end
        e.pc     = 16'(m_pc);
        e.flush  = m_flush;
        e.halted = m_halt;
        q.push_back(e);
    endtask

    task automatic do_cycle(input stim_t s);
        @(negedge clk);
        drive(s);
    endtask

    // Reset is pulled mid-cycle to show it acts without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", 32'(bif.o_pc), 32'h0000);
        chk("rst_flush", 32'(bif.o_flush), 32'h0);
        chk("rst_halted", 32'(bif.o_halted), 32'h0);
        m_pc = 0; m_halt = 0; m_flush = 0;
        @(negedge clk);
        rst = 1'b1;
        drive(idle());
    endtask

    initial begin : monitor
        exp_t e;
        logic t_s;
        forever begin
            @(negedge clk);
            #2 t_s = bif.o_taken;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("taken", 32'(t_s), 32'(e.taken));
                chk("pc", 32'(bif.o_pc), 32'(e.pc));
                chk("pc_plus2", 32'(bif.o_pc_plus2), 32'(16'(e.pc + 16'd2)));
                chk("flush", 32'(bif.o_flush), 32'(e.flush));
                chk("halted", 32'(bif.o_halted), 32'(e.halted));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        rst = 1'b0;
        bif.i_stall = 0; bif.i_branch = 0; bif.i_branch_reg = 0; bif.i_ccc = 0;
        bif.i_imm9 = 0; bif.i_reg_target = 0; bif.i_halt = 0; bif.i_flags = 0;
        bif.i_flags_next = 0; bif.i_flags_wen = 0;
        m_pc = 0; m_halt = 0; m_flush = 0;
        #3;
        chk("por_pc", 32'(bif.o_pc), 32'h0000);
        chk("por_flush", 32'(bif.o_flush), 32'h0);

        do_reset();
        repeat (7) do_cycle(idle());

        // Conditional B backwards while in the pc=0x0010 slot
        s = idle(); s.branch = 1; s.ccc = 3'b001; s.flags = 3'b100; s.imm9 = 9'h1FE;
        do_cycle(s);
        do_cycle(idle());
        do_cycle(idle());

        s = idle(); s.branch = 1; s.ccc = 3'b001; s.flags = 3'b000;
        s.flags_wen = 1; s.flags_next = 3'b100; s.imm9 = 9'h010;
        do_cycle(s);
        do_cycle(idle());
        s.flags_wen = 0;
        do_cycle(s);

        s = idle(); s.branch_reg = 1; s.ccc = 3'b111; s.tgt = 16'hFFFC;
        do_cycle(s);
        do_cycle(idle());
        do_cycle(idle());
        s = idle(); s.branch_reg = 1; s.ccc = 3'b111; s.tgt = 16'hFFFC;
        do_cycle(s);
        do_cycle(idle());
        s = idle(); s.branch = 1; s.ccc = 3'b111; s.imm9 = 9'h002;
        do_cycle(s);
        do_cycle(idle());

        s = idle(); s.branch = 1; s.branch_reg = 1; s.ccc = 3'b111;
        s.tgt = 16'h1234; s.imm9 = 9'h040;
        do_cycle(s);
        s = idle(); s.halt = 1;
        do_cycle(s);
        do_cycle(idle());

        s = idle(); s.branch = 1; s.ccc = 3'b111; s.imm9 = 9'h020; s.stall = 1;
        do_cycle(s);
        s.stall = 0;
        do_cycle(s);
        s = idle(); s.stall = 1; s.halt = 1;
        do_cycle(s);
        do_cycle(idle());

        s = idle(); s.branch = 1; s.ccc = 3'b111; s.imm9 = 9'h010;
        do_cycle(s);
        do_reset();

        s = idle(); s.halt = 1;
        do_cycle(s);
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.branch = 1; s.branch_reg = i[0]; s.ccc = 3'b111;
            s.imm9 = 9'($urandom); s.tgt = 16'($urandom);
            do_cycle(s);
        end
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if (m_halt && ($urandom_range(0, 5) == 0)) begin
                do_reset();
            end else begin
                s.stall      = ($urandom_range(0, 4) == 0);
                s.branch     = 1'($urandom);
                s.branch_reg = ($urandom_range(0, 4) == 0);
                s.ccc        = 3'($urandom);
                s.imm9       = 9'($urandom);
                s.tgt        = 16'($urandom);
                s.halt       = ($urandom_range(0, 29) == 0);
                s.flags      = 3'($urandom);
                s.flags_next = 3'($urandom);
                s.flags_wen  = 1'($urandom);
                do_cycle(s);
            end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("drain", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
